debug_reg_snapshot: RTL
=======================

# debug_reg_snapshot

Frame-coherent register shadow that sits directly upstream of the VGA debug screen. Once per frame, at the start of vertical sync, it walks the CPU register-file read port through all 32 registers under a request/grant handshake and captures them into a local 32x32 shadow. The debug screen then reads the shadow through its `regAddr`/`regData` pair, so every register shown in a frame comes from the same snapshot. The CPU port is only used during a capture.

## Interface
- `REG_COUNT`, 32: registers captured per snapshot (addresses 0..REG_COUNT-1).
- `DATA_W`, 32: register width.
- `VSYNC_ACTIVE`, 1'b0: vsync level that means "in sync pulse" (active-low VGA by default).

Ports:
- `clk`  in  1  single clock, shared with the VGA debug screen.
- `reset`  in  1  synchronous, active-high reset.
- `vsync`  in  1  vsync from the VGA timing generator (same clock domain).
- `freeze`  in  1  when high at a trigger, the snapshot is skipped and the display holds.
- `snap_req`  in  1  manual one-cycle trigger, equivalent to a vsync edge.
- `cpu_req`  out  1  read request to the CPU register-file port.
- `cpu_addr`  out  5  register address presented with `cpu_req`.
- `cpu_gnt`  in  1  grant; `cpu_data` is valid in the same cycle.
- `cpu_data`  in  DATA_W  register data from the CPU.
- `regAddr`  in  5  shadow read address from the debug screen.
- `regData`  out  DATA_W  shadow[regAddr], asynchronous (combinational) read.
- `snap_busy`  out  1  high while a capture is in progress.
- `snap_done`  out  1  one-cycle pulse when a capture completes.
- `snap_count`  out  16  number of completed captures; wraps from 16'hFFFF to 0.
- `overrun`  out  1  sticky; set when a trigger arrives while a capture is already running.

## Operation
- Trigger generation:
  - `vsync_d` registers `vsync`.
  - A trigger occurs when `vsync==VSYNC_ACTIVE && vsync_d!=VSYNC_ACTIVE`, or when `snap_req` is high.
- FSM states: IDLE, READ, DONE.
- IDLE:
  - On a trigger with `freeze==0`, go to READ with `addr=0`.
  - On a trigger with `freeze==1`, stay in IDLE; nothing else changes.
- READ:
  - `cpu_req=1` and `cpu_addr=addr`.
  - On `cpu_gnt`, write `shadow[addr] <= cpu_data`.
  - After the grant, if `addr==REG_COUNT-1` go to DONE; otherwise `addr <= addr+1` and stay in READ.
  - `cpu_req` stays high across consecutive addresses, so back-to-back grants are allowed.
  - Without a grant, `addr` and `cpu_addr` are held.
- DONE:
  - `cpu_req=0`, `snap_done=1`, `snap_count <= snap_count+1`.
  - Go to IDLE.
- `snap_busy` is high in READ and DONE.
- A trigger seen in READ or DONE is ignored for capture and sets `overrun`. Only `reset` clears `overrun`.
- `freeze` is sampled only at the trigger. Changing it mid-capture does not abort the capture.
- The shadow updates register by register during a capture. This is intended: the capture runs inside vertical blanking, and the 2-line sync pulse gives at least 32 grant opportunities.
- `regData` always reflects the current shadow contents; there is no read latency.

## Timing
- Reset (synchronous, highest priority):
  - State=IDLE, `addr=0`, `vsync_d=~VSYNC_ACTIVE`.
  - All 32 shadow entries cleared to 0, so `regData=0` for every address.
  - `cpu_req=0`, `cpu_addr=0`, `snap_busy=0`, `snap_done=0`, `snap_count=0`, `overrun=0`.
- Reset asserted mid-capture: `cpu_req` drops in the cycle after the reset edge; the partial snapshot is discarded (shadow cleared).
- Trigger sampled in cycle N: `cpu_req=1` and `cpu_addr=0` in cycle N+1.
- Grant in cycle M: the new data is visible on `regData` from cycle M+1.
- Last grant in cycle L: DONE in L+1 (`snap_done=1`, `cpu_req=0`); `snap_count` updated in L+2; IDLE in L+2.
- With `cpu_gnt` tied high: READ lasts exactly 32 cycles, the capture takes 33 cycles from trigger to `snap_done`, and the next trigger is accepted from L+2.
- A trigger in the same cycle as DONE is an overrun and is not queued.
- A vsync held active does not retrigger; a new trigger needs an inactive-to-active transition.

## Test plan
- Reset, then read all 32 `regAddr` values: `regData=0` for each; all outputs at their reset values.
- `cpu_gnt=1`, CPU regs = `32'hA5000000+i`, one vsync falling edge: `cpu_req` for 32 cycles with addresses 0..31; `snap_done` pulses 33 cycles after the trigger; `regData` at addr 7 = `32'hA5000007`; `snap_count=1`.
- Grant every third cycle: `cpu_addr` holds between grants; the capture finishes after 96 READ cycles with a correct shadow.
- `freeze=1` at the vsync edge after the CPU regs change to `32'h0`: no `cpu_req`, shadow still holds `32'hA50000xx`, `snap_count` unchanged.
- `snap_req` pulse at addr 10 of a stalled capture: `overrun=1`; the capture completes once; `snap_count` increments by exactly 1.
- Reset asserted while `cpu_addr=15`: `cpu_req=0` the next cycle, shadow all 0; a subsequent vsync edge captures all 32 registers normally.

Source files
------------

// File: rtl/debug_reg_snapshot.sv
// debug_reg_snapshot
// Frame-coherent shadow of the CPU register file for the VGA debug screen.
// A capture walks the CPU read port through every register under a
// request/grant handshake. The debug screen reads the shadow combinationally,
// so everything it shows in one frame comes from a single snapshot.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a vsync edge or snap_req; CPU port untouched
// READ  | cpu_req high, one shadow entry written per grant
// DONE  | one-cycle completion pulse, capture counter advances
module debug_reg_snapshot #(
  parameter int   REG_COUNT    = 32,
  parameter int   DATA_W       = 32,
  parameter logic VSYNC_ACTIVE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              freeze,
  input  logic              snap_req,
  output logic              cpu_req,
  output logic [4:0]        cpu_addr,
  input  logic              cpu_gnt,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic [4:0]        regAddr,
  output logic [DATA_W-1:0] regData,
  output logic              snap_busy,
  output logic              snap_done,
  output logic [15:0]       snap_count,
  output logic              overrun
);

  localparam logic [4:0] LAST_ADDR = 5'(REG_COUNT - 1);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t            state_q;
  logic              vsync_q;
  logic [4:0]        addr_q;
  logic              cpu_req_q;
  logic              busy_q;
  logic              done_q;
  logic [15:0]       count_q;
  logic              overrun_q;
  logic [DATA_W-1:0] shadow_q [REG_COUNT];

  logic              trigger;
  logic              shadow_we;

  // Inactive-to-active vsync transition or a manual request starts a capture.
  assign trigger   = ((vsync == VSYNC_ACTIVE) && (vsync_q != VSYNC_ACTIVE)) || snap_req;
  assign shadow_we = (state_q == READ) && cpu_gnt;

  // Capture sequencer with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      vsync_q   <= ~VSYNC_ACTIVE;
      addr_q    <= '0;
      cpu_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
      // Triggers during a capture are dropped, not queued; remember that it happened.
      if (trigger && (state_q != IDLE)) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (trigger && !freeze) begin
            state_q   <= READ;
            addr_q    <= '0;
            cpu_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        READ: begin
          if (cpu_gnt) begin
            if (addr_q == LAST_ADDR) begin
              state_q   <= DONE;
              cpu_req_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              addr_q <= addr_q + 5'd1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          count_q <= count_q + 16'd1;
        end
        default: begin
          state_q   <= IDLE;
          cpu_req_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  // Shadow storage; a reset mid-capture discards the partial snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) shadow_q[i] <= '0;
    end else if (shadow_we) begin
      shadow_q[addr_q] <= cpu_data;
    end
  end

  assign regData    = shadow_q[regAddr];
  assign cpu_req    = cpu_req_q;
  assign cpu_addr   = addr_q;
  assign snap_busy  = busy_q;
  assign snap_done  = done_q;
  assign snap_count = count_q;
  assign overrun    = overrun_q;

endmodule
